// File: rtl/byte_serial_pkg.sv
// byte_serial_pkg
//   Shared types and constants for the byte-serial accumulator.
//   - state_t : FSM encoding (IDLE, ADD, DONE)
//   - BYTE_W  : width of one arithmetic slice
//   - nbytes  : number of byte slices needed for an accumulator width
package byte_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_W = 8;

  function automatic int nbytes(input int acc_w);
    return acc_w / BYTE_W;
  endfunction

endpackage

// File: rtl/byte_serial_accumulator_adder8.sv
// adder8
//   8-bit ripple-carry adder slice, purely combinational, assembled from
//   1-bit full-adder cells.
//   Ports:
//     a, b   : byte operands
//     c_in   : carry into bit 0
//     o      : byte sum
//     c_out  : carry out of bit 7
module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] o,
  output logic       c_out
);

  logic [8:0] c;

  assign c[0] = c_in;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign o[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign c_out = c[8];

endmodule

// File: rtl/byte_serial_accumulator.sv
// byte_serial_accumulator
//   Accumulates a frame of N_SAMPLES unsigned 16-bit samples into an
//   ACC_W-bit total, one byte per clock through a single adder8 slice with
//   the carry registered between bytes. The frame total and a sticky
//   overflow flag are presented for one cycle at the end of each frame.
//   Ports:
//     clock, reset_n : clock and asynchronous active-low reset
//     clear          : synchronous frame abort; returns to IDLE, zeroes state
//     in_valid/in_ready/in_data : sample input handshake
//     acc_out, acc_valid, overflow : frame result, valid for one cycle
//     count          : samples fully added in the current frame
//     state_dbg      : current FSM state, for observation only
//
//   Handshake: a sample transfers on a rising edge where in_valid and
//   in_ready are both high. in_ready depends only on the FSM state, clear
//   and reset_n, never on in_valid. in_valid is ignored when in_ready is low;
//   the producer holds in_data stable until the transfer edge. The result
//   side has no backpressure: acc_valid is a single-cycle pulse.
module byte_serial_accumulator
  import byte_serial_pkg::*;
#(
  parameter int  ACC_W     = 24,
  parameter int  N_SAMPLES = 16,
  localparam int CW        = $clog2(N_SAMPLES + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             overflow,
  output logic [CW-1:0]    count,
  output state_t           state_dbg
);

  localparam int NB = nbytes(ACC_W);
  localparam int KW = $clog2(NB);

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic               carry_q, carry_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;

  logic [BYTE_W-1:0]  a_byte, b_byte, sum_byte;
  logic               slice_cout;

  // Byte mux: select byte k of the accumulator and of the operand.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (KW'(i) == k_q) begin
        a_byte = acc_q[i*BYTE_W +: BYTE_W];
        b_byte = opnd_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  adder8 u_adder8 (
    .a     (a_byte),
    .b     (b_byte),
    .c_in  (carry_q),
    .o     (sum_byte),
    .c_out (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    if (clear) begin
      state_d = IDLE;
      k_d     = '0;
      carry_d = 1'b0;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opnd_d  = ACC_W'(in_data);
            k_d     = '0;
            carry_d = 1'b0;
            state_d = ADD;
          end
        end
        ADD: begin
          // Byte demux: write the slice sum back into byte k.
          for (int i = 0; i < NB; i++) begin
            if (KW'(i) == k_q) acc_d[i*BYTE_W +: BYTE_W] = sum_byte;
          end
          carry_d = slice_cout;
          if (k_q == KW'(NB - 1)) begin
            // Carry out of the top byte is the accumulator overflow; it is
            // folded into the sticky flag, not carried into the next sample.
            ovf_d   = ovf_q | slice_cout;
            carry_d = 1'b0;
            k_d     = '0;
            count_d = count_q + CW'(1);
            state_d = (count_q + CW'(1) == CW'(N_SAMPLES)) ? DONE : IDLE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
        DONE: begin
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      opnd_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // in_ready is gated by reset_n so it is low throughout reset.
  assign in_ready  = reset_n && (state_q == IDLE) && !clear;
  assign acc_valid = (state_q == DONE);
  assign acc_out   = acc_q;
  assign overflow  = ovf_q;
  assign count     = count_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_byte_serial_accumulator.sv
module tb_byte_serial_accumulator;
  import byte_serial_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A: ACC_W=24, N=4 ----------------
  logic        a_clear = 0, a_valid = 0;
  logic [15:0] a_data = '0;
  logic        a_ready, a_av, a_ovf;
  logic [23:0] a_acc;
  logic [2:0]  a_cnt;
  state_t      a_st;

  byte_serial_accumulator #(.ACC_W(24), .N_SAMPLES(4)) dut_a (
    .clock(clk), .reset_n(reset_n), .clear(a_clear), .in_valid(a_valid),
    .in_data(a_data), .in_ready(a_ready), .acc_out(a_acc), .acc_valid(a_av),
    .overflow(a_ovf), .count(a_cnt), .state_dbg(a_st)
  );

  // ---------------- DUT B: ACC_W=16, N=2 ----------------
  logic        b_clear = 0, b_valid = 0;
  logic [15:0] b_data = '0;
  logic        b_ready, b_av, b_ovf;
  logic [15:0] b_acc;
  logic [1:0]  b_cnt;
  state_t      b_st;

  byte_serial_accumulator #(.ACC_W(16), .N_SAMPLES(2)) dut_b (
    .clock(clk), .reset_n(reset_n), .clear(b_clear), .in_valid(b_valid),
    .in_data(b_data), .in_ready(b_ready), .acc_out(b_acc), .acc_valid(b_av),
    .overflow(b_ovf), .count(b_cnt), .state_dbg(b_st)
  );

  // ---------------- DUT C: ACC_W=24, N=16 ----------------
  logic        c_clear = 0, c_valid = 0;
  logic [15:0] c_data = '0;
  logic        c_ready, c_av, c_ovf;
  logic [23:0] c_acc;
  logic [4:0]  c_cnt;
  state_t      c_st;

  byte_serial_accumulator #(.ACC_W(24), .N_SAMPLES(16)) dut_c (
    .clock(clk), .reset_n(reset_n), .clear(c_clear), .in_valid(c_valid),
    .in_data(c_data), .in_ready(c_ready), .acc_out(c_acc), .acc_valid(c_av),
    .overflow(c_ovf), .count(c_cnt), .state_dbg(c_st)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard for DUT A: each entry is {overflow, acc_out}.
  logic [24:0] exp_q[$];
  int          a_valid_cyc = -1;

  always @(posedge clk) begin
    #1;
    if (a_av) begin
      a_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("a_unexpected_valid", 32'(a_acc), 32'hFFFF_FFFF);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        check("a_acc", 32'(a_acc), 32'(e[23:0]));
        check("a_ovf", 32'(a_ovf), 32'(e[24]));
        check("a_count", 32'(a_cnt), 32'd4);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Each returns the edge index (cyc value after the edge) of the accept.
  task automatic send_a(input logic [15:0] d, output int ec);
    bit done = 0;
    ec = -1;
    a_valid = 1; a_data = d;
    for (int i = 0; i < 20 && !done; i++) begin
      if (a_ready) done = 1;
      @(posedge clk); #1;
      if (done) ec = cyc;
    end
    if (!done) check("a_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_b(input logic [15:0] d);
    bit done = 0;
    b_valid = 1; b_data = d;
    for (int i = 0; i < 20 && !done; i++) begin
      if (b_ready) done = 1;
      @(posedge clk); #1;
    end
    if (!done) check("b_accept_timeout", 32'd0, 32'd1);
  endtask

  // Waits (bounded) until the selected DUT shows acc_valid.
  task automatic wait_pulse(input int which, input string tag);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if ((which == 0) ? a_av : b_av) seen = 1;
      else begin @(posedge clk); #1; end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int e[0:7];
  int v_cyc;
  int n_acc;
  bit got_c;

  initial begin
    // Reset check: outputs low and in_ready low while reset_n is low.
    #3;
    check("rst_ready", 32'(a_ready), 32'd0);
    check("rst_acc", 32'(a_acc), 32'd0);
    check("rst_valid", 32'(a_av), 32'd0);
    check("rst_ovf", 32'(a_ovf), 32'd0);
    check("rst_count", 32'(a_cnt), 32'd0);
    check("rst_state", 32'(a_st), 32'(IDLE));
    #19 reset_n = 1;   // t=22, between edges
    #1;
    check("post_rst_ready", 32'(a_ready), 32'd1);
    check("post_rst_count", 32'(a_cnt), 32'd0);
    @(posedge clk); #1;

    // Carry propagation: 1 + 0xFF + 0xFFFF + 0x100 = 0x0101FF.
    exp_q.push_back({1'b0, 24'h0101FF});
    send_a(16'h0001, e[0]);
    send_a(16'h00FF, e[1]);
    send_a(16'hFFFF, e[2]);
    send_a(16'h0100, e[3]);
    check("gap_01", 32'(e[1] - e[0]), 32'd4);
    check("gap_12", 32'(e[2] - e[1]), 32'd4);
    check("gap_23", 32'(e[3] - e[2]), 32'd4);
    a_data = 16'h8000;  // keep in_valid high across DONE
    wait_pulse(0, "a_valid_seen_carry");
    v_cyc = cyc;
    // The cycle following edge n is numbered n+1.
    check("latency", 32'(v_cyc + 1 - e[3]), 32'd4);

    // Next frame: first accept comes one cycle later because of DONE.
    send_a(16'h8000, e[4]);
    check("gap_done", 32'(e[4] - e[3]), 32'd5);
    send_a(16'h8000, e[5]);
    send_a(16'h8000, e[6]);
    a_valid = 0;
    // Now in byte-0 cycle of sample 3; advance to byte 1 and abort.
    @(posedge clk); #1;
    a_clear = 1;
    @(posedge clk); #1;
    a_clear = 0;
    #1;
    check("abort_count", 32'(a_cnt), 32'd0);
    check("abort_ready", 32'(a_ready), 32'd1);
    check("abort_acc", 32'(a_acc), 32'd0);

    // Clean frame after abort: 4 x 0x10 = 0x40.
    exp_q.push_back({1'b0, 24'h000040});
    for (int i = 0; i < 4; i++) send_a(16'h0010, e[7]);
    a_valid = 0;
    wait_pulse(0, "a_valid_seen_abort");
    @(posedge clk); #1;
    check("post_done_count", 32'(a_cnt), 32'd0);

    // Async reset mid-ADD: nothing must be emitted for the lost frame.
    send_a(16'h0001, e[0]);
    send_a(16'h0002, e[1]);
    send_a(16'h0003, e[2]);
    a_valid = 0;
    @(posedge clk); #1;   // byte-1 cycle of sample 3
    #1 reset_n = 0;
    #1;
    check("arst_acc", 32'(a_acc), 32'd0);
    check("arst_count", 32'(a_cnt), 32'd0);
    check("arst_ready", 32'(a_ready), 32'd0);
    check("arst_valid", 32'(a_av), 32'd0);
    #1 reset_n = 1;
    repeat (15) @(posedge clk);
    #1;
    check("arst_ready_after", 32'(a_ready), 32'd1);
    // Recovery frame: 4 x 1 = 4.
    exp_q.push_back({1'b0, 24'h000004});
    for (int i = 0; i < 4; i++) send_a(16'h0001, e[7]);
    a_valid = 0;
    wait_pulse(0, "a_valid_seen_recover");
    @(posedge clk); #1;

    // Overflow on DUT B: 0xFFFF + 0x0002 = 0x10001 -> 0x0001, overflow.
    send_b(16'hFFFF);
    send_b(16'h0002);
    b_valid = 0;
    wait_pulse(1, "b_valid_seen_ovf");
    check("b_acc_ovf", 32'(b_acc), 32'h0001);
    check("b_ovf_set", 32'(b_ovf), 32'd1);
    check("b_count_done", 32'(b_cnt), 32'd2);
    @(posedge clk); #1;
    check("b_acc_cleared", 32'(b_acc), 32'd0);
    check("b_ovf_cleared", 32'(b_ovf), 32'd0);
    send_b(16'h0001);
    send_b(16'h0002);
    b_valid = 0;
    wait_pulse(1, "b_valid_seen_next");
    check("b_acc_next", 32'(b_acc), 32'h0003);
    check("b_ovf_next", 32'(b_ovf), 32'd0);
    @(posedge clk); #1;

    // Handshake on DUT C: in_valid held high for a whole 16-sample frame.
    c_valid = 1; c_data = 16'h1234;
    n_acc = 0; got_c = 0;
    for (int i = 0; i < 200 && !got_c; i++) begin
      if (c_ready) n_acc++;
      @(posedge clk); #1;
      if (c_av) got_c = 1;
    end
    check("c_valid_seen", 32'(got_c), 32'd1);
    check("c_accepts", 32'(n_acc), 32'd16);
    check("c_acc", 32'(c_acc), 32'h012340);
    check("c_ovf", 32'(c_ovf), 32'd0);
    check("c_count", 32'(c_cnt), 32'd16);
    c_valid = 0;
    @(posedge clk); #1;

    check("a_exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_serial_accumulator.md
# byte_serial_accumulator

Consumes the 16-bit sums produced by the adder stage and accumulates a frame of N_SAMPLES of them into an ACC_W-bit total. The addition is byte-serial: one 8-bit ripple slice adds one byte per clock, with the carry held in a register between bytes. This trades throughput for area, matching the byte-sliced arithmetic style already used in the datapath. At the end of each frame the block presents the total and an overflow flag to the downstream consumer for one cycle.

## Interface
- ACC_W, 24, accumulator width in bits; must be a multiple of 8 and at least 16. NB = ACC_W/8 is the number of byte cycles per sample.
- N_SAMPLES, 16, number of samples per frame; must be at least 1.
- clock  in  1  rising-edge clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous frame abort and clear.
- in_valid  in  1  upstream sample valid.
- in_data  in  16  upstream sample, unsigned, zero-extended to ACC_W.
- in_ready  out  1  block can accept a sample this cycle.
- acc_out  out  ACC_W  frame total; meaningful only while acc_valid is high.
- acc_valid  out  1  one-cycle pulse marking the frame result.
- overflow  out  1  sticky flag: carry out of the ACC_W-bit accumulator occurred during the frame; valid with acc_valid.
- count  out  $clog2(N_SAMPLES+1)  number of samples fully added in the current frame.

## Operation
- FSM states:
  - IDLE: in_ready = !clear.
  - ADD: byte index k runs 0..NB-1.
  - DONE
- Accept: a sample is accepted on a rising edge where in_valid && in_ready. On accept, latch the operand as {zeros, in_data}, set k=0, clear the carry register, and go to ADD.
- ADD, per cycle k:
  - acc[8k+7:8k] <= acc byte k + operand byte k + carry.
  - carry <= the slice carry-out.
- ADD, last byte (k = NB-1):
  - overflow <= overflow | carry-out.
  - count <= count+1.
  - Next state is DONE if count+1 == N_SAMPLES, otherwise IDLE.
- DONE (one cycle):
  - acc_valid=1; acc_out = final total; overflow and count = N_SAMPLES.
  - Next edge: acc, count and overflow go to 0 and the FSM returns to IDLE.
- Arithmetic:
  - Unsigned, modulo 2^ACC_W; wrap-around is reported only via overflow.
  - Byte carries never leak between samples.
- clear: when high at an edge, in any state, go to IDLE with acc, carry, count, overflow and k at 0 and acc_valid low. Any in-progress sample is discarded. clear takes priority over accept and over DONE.
- in_valid is ignored outside IDLE. Upstream must hold in_data stable until the handshake completes.
- Reset (reset_n low, asynchronous):
  - state=IDLE; acc, carry, count, k at 0.
  - Outputs: acc_out=0, acc_valid=0, overflow=0, count=0.
  - in_ready is forced 0 while reset_n is low and rises in the first cycle after release.
- Reset mid-sample or mid-frame loses all partial state; no result is emitted.

## Timing
- Accept edge at t: ADD occupies cycles t+1..t+NB. in_ready is high again in cycle t+NB+1, or in cycle t+NB+2 if a DONE cycle intervenes.
- Sustained throughput is one sample per NB+1 cycles, plus one extra cycle per frame for DONE.
- Latency from the last sample's accept edge to acc_valid is NB+1 cycles.
- acc_valid is high for exactly one cycle; there is no backpressure on the result.
- count updates on the edge that completes byte NB-1.

## Structure
- Package byte_serial_pkg holds:
  - state enum {IDLE, ADD, DONE}
  - BYTE_W=8
  - helper function nbytes(ACC_W)
- Sub-module adder8: 8-bit ripple-carry slice built from 1-bit full-adder cells. Ports a[7:0], b[7:0], c_in, o[7:0], c_out; purely combinational.
- Top level contains the FSM, byte index, carry register, accumulator and operand registers, and the byte mux/demux around one adder8 instance.

## Test plan
- Reset check: while reset_n is held low, all outputs are 0 and in_ready=0. After release, in_ready=1 and count=0.
- Carry propagation (ACC_W=24, N_SAMPLES=4): send 0x0001, 0x00FF, 0xFFFF, 0x0100 back-to-back. Required: acc_valid exactly 4 cycles after the last accept edge, acc_out=0x0101FF, overflow=0, count=4. Accept edges must be 4 cycles apart, plus 1 across DONE.
- Overflow (ACC_W=16, N_SAMPLES=2): send 0xFFFF then 0x0002. Required: acc_out=0x0001, overflow=1. The next frame starts with acc=0 and overflow=0.
- Abort: assert clear during byte 1 of the third sample of a 4-sample frame. Required: next cycle count=0 and in_ready=1. A following 4-sample frame of 0x0010 each yields acc_out=0x000040.
- Handshake: hold in_valid high continuously with in_data changing only on accept edges. Required: no sample is lost or duplicated; N_SAMPLES=16 samples of 0x1234 give acc_out=0x012340.
- Async reset mid-ADD: pulse reset_n low for a fraction of a cycle. Required: outputs go to 0 immediately and there is no acc_valid pulse afterward.
